// File: rtl/core_dmem_wb_master.sv
// core_dmem_wb_master: MEM-stage load/store to Wishbone B4 classic data master
// with byte-lane steering, load extension, bus error/timeout and misalign reporting.
module core_dmem_wb_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_addr_mem,
  input  logic [31:0] mem_wdata_mem,
  input  logic        mem_write_mem,
  input  logic        mem_read_mem,
  input  logic [2:0]  mem_op_mem,
  output logic [31:0] mem_rdata_mem,
  output logic        stall_pipl,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        bus_err_o,
  output logic        misalign_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [1:0] off_q, off_d;
  logic [31:0] rdata_q, rdata_d, adr_q, adr_d, dat_q, dat_d;
  logic [3:0] sel_q, sel_d;
  logic cyc_q, cyc_d, we_q, we_d, bus_err_q, bus_err_d, misalign_q, misalign_d;
  logic req, mis, timeout;
  logic [3:0] sel_n;
  logic [31:0] dat_n, sh, ld;
  assign req = mem_read_mem | mem_write_mem;
  // op[1] set means word (including the undefined codes 011/110/111)
  assign mis = mem_op_mem[1] ? |mem_addr_mem[1:0] : mem_op_mem[0] & mem_addr_mem[0];
  assign sel_n = mem_op_mem[1] ? 4'b1111 : ((mem_op_mem[0] ? 4'b0011 : 4'b0001) << mem_addr_mem[1:0]);
  assign dat_n = mem_op_mem[1] ? mem_wdata_mem :
                 mem_op_mem[0] ? {2{mem_wdata_mem[15:0]}} : {4{mem_wdata_mem[7:0]}};
  assign sh = wb_dat_i >> {off_q, 3'b000};
  assign ld = op_q[1] ? sh :
              op_q[0] ? {{16{~op_q[2] & sh[15]}}, sh[15:0]} : {{24{~op_q[2] & sh[7]}}, sh[7:0]};
  assign timeout = cnt_q == TO_W'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    off_d = off_q;
    rdata_d = rdata_q;
    adr_d = adr_q;
    dat_d = dat_q;
    sel_d = sel_q;
    cyc_d = cyc_q;
    we_d = we_q;
    bus_err_d = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        if (mis) begin
          state_d = DONE;
          misalign_d = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = BUSY;
          cnt_d = '0;
          cyc_d = 1'b1;
          we_d = mem_write_mem;
          adr_d = {mem_addr_mem[31:2], 2'b00};
          dat_d = dat_n;
          sel_d = sel_n;
          op_d = mem_op_mem;
          off_d = mem_addr_mem[1:0];
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (wb_err_i || timeout) begin
          state_d = DONE;
          cyc_d = 1'b0;
          rdata_d = '0;
          bus_err_d = 1'b1;
        end else if (wb_ack_i) begin
          state_d = DONE;
          cyc_d = 1'b0;
          rdata_d = we_q ? '0 : ld;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      off_q <= '0;
      rdata_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      cyc_q <= 1'b0;
      we_q <= 1'b0;
      bus_err_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      off_q <= off_d;
      rdata_q <= rdata_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
      cyc_q <= cyc_d;
      we_q <= we_d;
      bus_err_q <= bus_err_d;
      misalign_q <= misalign_d;
    end
  assign stall_pipl = (state_q == IDLE && req) || state_q == BUSY;
  assign mem_rdata_mem = rdata_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign bus_err_o = bus_err_q;
  assign misalign_o = misalign_q;
endmodule

// File: doc/core_dmem_wb_master.md
Name: core_dmem_wb_master

Overview:
- Data-side bus master between the core's MEM-stage memory port and a Wishbone B4 classic data bus.
- Turns each load or store in the MEM stage into one Wishbone cycle and generates byte selects.
- Aligns and sign- or zero-extends load data before returning it to the core.
- Holds the whole pipeline via stall_pipl until the access completes. Reports bus errors, timeouts and misaligned accesses.

Parameters:
- TIMEOUT_CYCLES, 255: number of BUSY cycles without ack/err before the access is aborted. Must be ≥1.
- TO_W, 8: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- mem_addr_mem  in  32  MEM-stage byte address
- mem_wdata_mem  in  32  store data, right-justified
- mem_write_mem  in  1  store request
- mem_read_mem  in  1  load request
- mem_op_mem  in  3  funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_rdata_mem  out  32  aligned and extended load result
- stall_pipl  out  1  pipeline hold
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_adr_o  out  32  word address {addr[31:2],2'b00}
- wb_dat_o  out  32  write data, replicated per lane
- wb_sel_o  out  4  byte lane selects
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  Wishbone acknowledge
- wb_err_i  in  1  Wishbone error
- bus_err_o  out  1  one-cycle pulse on err or timeout
- misalign_o  out  1  one-cycle pulse on a misaligned access

Behaviour:
- Reset: state=IDLE. All registered outputs (mem_rdata_mem, wb_*_o, bus_err_o, misalign_o) are 0 and the timeout counter is 0.
- Request definition: req = mem_read_mem | mem_write_mem. If both are asserted, the access is a write.
- FSM states: IDLE, BUSY, DONE.
- IDLE, stall_pipl:
  - stall_pipl = req, combinational.
- IDLE, misaligned request (H/HU with addr[0]=1, or W with addr[1:0]≠0):
  - No bus cycle is issued.
  - Next state DONE; misalign_o pulses on entry to DONE; mem_rdata_mem = 0.
- IDLE, aligned request:
  - Register wb_adr_o, wb_we_o and wb_sel_o.
  - wb_dat_o: byte store → {4{wdata[7:0]}}; half store → {2{wdata[15:0]}}; word store → wdata.
  - wb_cyc_o = wb_stb_o = 1 from the next cycle. Next state BUSY.
  - wb_sel_o: B → 1<<addr[1:0]; H → 4'b0011<<addr[1:0]; W → 4'b1111.
- BUSY:
  - stall_pipl = 1. cyc, stb, adr, dat, sel and we are held stable. The counter increments each cycle.
  - On wb_ack_i: latch the aligned load result (writes latch 0), drop cyc/stb, go to DONE.
  - On wb_err_i, or when the counter reaches TIMEOUT_CYCLES: drop cyc/stb, mem_rdata_mem = 0, pulse bus_err_o, go to DONE.
  - If ack and err arrive in the same cycle, err wins.
- DONE:
  - Lasts exactly one cycle with stall_pipl = 0, so the core advances the MEM stage. Next state IDLE. The counter clears.
  - The instruction that then enters the MEM stage is evaluated in IDLE the following cycle. Back-to-back accesses therefore cost at least 3 cycles each.
- Load alignment: shift wb_dat_i right by 8*addr[1:0].
  - B/H sign-extend bit 7/15.
  - BU/HU zero-extend.
  - W passes unchanged.
- mem_rdata_mem holds its value until the next DONE.
- An unknown mem_op code (011, 110, 111) is treated as W.
- Asynchronous reset mid-cycle (BUSY) forces IDLE with cyc/stb low immediately. No error pulse is produced.

Test Plan:
- LW, addr 0x100, slave acks after 2 wait states with 0xDEADBEEF → wb_sel=1111, stall_pipl high for 4 cycles, mem_rdata_mem=0xDEADBEEF in DONE.
- LB, addr 0x103, wb_dat_i=0x80112233 → sel=1000, rdata=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH, addr 0x202, wdata=0x0000ABCD → wb_we=1, sel=1100, wb_dat_o=0xABCDABCD, adr=0x200.
- LW at 0x101 → no wb_cyc, misalign_o pulses once, stall_pipl high for 1 cycle, rdata=0.
- Slave never acks, TIMEOUT_CYCLES=4 → cyc dropped after 4 BUSY cycles, bus_err_o single pulse, pipeline resumes. Repeat with wb_err_i asserted on the same cycle as ack → error path taken.
- reset_n pulled low during BUSY → cyc/stb drop the same cycle. After release, a new LW completes normally.
